// File: rtl/hazard_forward_unit_if.sv
// Fetch-side bundle for the hazard/forward unit: instruction in, stall back,
// decoded fields, forward selects and data-memory controls out.
interface hazard_forward_unit_if #(
  parameter int INS_W     = 24,
  parameter int OP_W      = 5,
  parameter int REG_W     = 5,
  parameter int IMM_W     = 8,
  parameter int FWD_DEPTH = 3,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
);
  logic [INS_W-1:0] ins;
  logic             ins_valid;
  logic             stall;
  logic [OP_W-1:0]  op_dec;
  logic [IMM_W-1:0] imm;
  logic             imm_sel;
  logic [SEL_W-1:0] mux_sel_A;
  logic [SEL_W-1:0] mux_sel_B;
  logic             mem_en_ex;
  logic             mem_rw_ex;
  logic             mem_mux_sel_dm;
  logic [REG_W-1:0] RW_dm;

  modport master (
    output ins, ins_valid,
    input  stall, op_dec, imm, imm_sel, mux_sel_A, mux_sel_B,
           mem_en_ex, mem_rw_ex, mem_mux_sel_dm, RW_dm
  );

  modport slave (
    input  ins, ins_valid,
    output stall, op_dec, imm, imm_sel, mux_sel_A, mux_sel_B,
           mem_en_ex, mem_rw_ex, mem_mux_sel_dm, RW_dm
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Decode slot plus a FWD_DEPTH-deep destination history: produces operand
// forward selects, a one-cycle load-use stall and EX/writeback memory controls.
module hazard_forward_unit #(
  parameter int             INS_W     = 24,
  parameter int             OP_W      = 5,
  parameter int             REG_W     = 5,
  parameter int             IMM_W     = 8,
  parameter int             FWD_DEPTH = 3,
  parameter logic [OP_W-1:0] OP_LD    = 5'b10100,
  parameter logic [OP_W-1:0] OP_ST    = 5'b10101,
  parameter logic [OP_W-1:0] OP_JMP   = 5'b11000,
  parameter int             SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input logic                 clk,
  input logic                 reset,
  hazard_forward_unit_if.slave bus
);
  localparam int RD_LSB  = INS_W - OP_W - REG_W;
  localparam int RSA_LSB = RD_LSB - REG_W;
  localparam int RSB_LSB = RSA_LSB - REG_W;

  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs_a;
    logic [REG_W-1:0] rs_b;
    logic [IMM_W-1:0] imm;
    logic             is_imm;
    logic             is_ld;
    logic             is_st;
    logic             wd;
  } dslot_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             wd;
    logic             is_ld;
    logic             is_st;
  } hist_t;

  dslot_t d_reg, d_next, d_in;
  hist_t  hist_reg  [1:FWD_DEPTH];
  hist_t  hist_next [1:FWD_DEPTH];

  logic [OP_W-1:0]    in_op;
  logic [REG_W-1:0]   in_rd;
  logic               in_is_st, in_is_jmp, in_is_jcc;
  logic               stall;
  logic [FWD_DEPTH:1] match_a, match_b;
  logic [SEL_W-1:0]   sel_a, sel_b;
  logic               unused_bits;

  assign in_op     = bus.ins[INS_W-1 -: OP_W];
  assign in_rd     = bus.ins[RD_LSB +: REG_W];
  assign in_is_st  = (in_op == OP_ST);
  assign in_is_jmp = (in_op == OP_JMP);
  assign in_is_jcc = (in_op[OP_W-1 -: 3] == 3'b111);
  assign unused_bits = bus.ins[0];

  // A bubble is all zeros, so empty slots never look like a real R0 writer.
  always_comb begin
    d_in = '0;
    if (bus.ins_valid) begin
      d_in.valid  = 1'b1;
      d_in.op     = in_op;
      d_in.rd     = in_rd;
      d_in.rs_a   = bus.ins[RSA_LSB +: REG_W];
      d_in.rs_b   = bus.ins[RSB_LSB +: REG_W];
      d_in.imm    = bus.ins[IMM_W:1];
      d_in.is_imm = (in_op[OP_W-1 -: 2] == 2'b01);
      d_in.is_ld  = (in_op == OP_LD);
      d_in.is_st  = in_is_st;
      d_in.wd     = ~in_is_st & ~in_is_jmp & ~in_is_jcc & (in_rd != '0);
    end
  end

  assign stall = d_reg.valid & hist_reg[1].is_ld & hist_reg[1].wd &
                 ((d_reg.rs_a == hist_reg[1].rd) |
                  (~d_reg.is_imm & (d_reg.rs_b == hist_reg[1].rd)));

  always_comb begin
    d_next = d_in;
    if (stall) d_next = d_reg;
  end

  always_comb begin
    hist_next[1] = '0;
    if (!stall) hist_next[1] = '{rd: d_reg.rd, wd: d_reg.wd, is_ld: d_reg.is_ld, is_st: d_reg.is_st};
  end

  generate
    for (genvar gi = 2; gi <= FWD_DEPTH; gi++) begin : g_shift
      assign hist_next[gi] = hist_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      d_reg <= '0;
      for (int k = 1; k <= FWD_DEPTH; k++) hist_reg[k] <= '0;
    end else begin
      d_reg    <= d_next;
      hist_reg <= hist_next;
    end
  end

  // The loaded value is not available from stage 1 while stalling on it.
  generate
    for (genvar gi = 1; gi <= FWD_DEPTH; gi++) begin : g_match
      if (gi == 1) begin : g_young
        assign match_a[gi] = hist_reg[gi].wd & (hist_reg[gi].rd == d_reg.rs_a) & ~stall;
        assign match_b[gi] = hist_reg[gi].wd & (hist_reg[gi].rd == d_reg.rs_b) & ~stall;
      end else begin : g_old
        assign match_a[gi] = hist_reg[gi].wd & (hist_reg[gi].rd == d_reg.rs_a);
        assign match_b[gi] = hist_reg[gi].wd & (hist_reg[gi].rd == d_reg.rs_b);
      end
    end
  endgenerate

  // Scan oldest to youngest so the youngest producer overwrites.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (match_a[k]) sel_a = SEL_W'(k);
      if (match_b[k]) sel_b = SEL_W'(k);
    end
    if (!d_reg.valid || d_reg.rs_a == '0) sel_a = '0;
    if (!d_reg.valid || d_reg.rs_b == '0 || d_reg.is_imm) sel_b = '0;
  end

  assign bus.stall          = stall;
  assign bus.op_dec         = d_reg.op;
  assign bus.imm            = d_reg.imm;
  assign bus.imm_sel        = d_reg.is_imm;
  assign bus.mux_sel_A      = sel_a;
  assign bus.mux_sel_B      = sel_b;
  assign bus.mem_en_ex      = hist_reg[1].is_ld | hist_reg[1].is_st;
  assign bus.mem_rw_ex      = hist_reg[1].is_st;
  assign bus.mem_mux_sel_dm = hist_reg[2].is_ld & hist_reg[2].wd;
  assign bus.RW_dm          = hist_reg[2].wd ? hist_reg[2].rd : '0;
endmodule
